passcode_checker: RTL and testbench
===================================

// Module: passcode_checker
// PURPOSE
//  Door-lock decision stage. Collects decimal digits from the keypad decoder,
//  compares a full entry against a stored passcode, and drives 'unlock', which
//  feeds the LED indicator stage's led_in. Holds unlock for a fixed time, and
//  enforces a lockout period after repeated failed entries.
// PARAMETERS
//  CODE_LEN        4           digits per passcode entry
//  DIGIT_W         4           bits per digit (BCD)
//  PASSCODE        16'h1234    stored code, MS digit = first digit entered
//  UNLOCK_CYCLES   100000000   clk cycles unlock stays high (1 s @ 100 MHz)
//  MAX_FAILS       3           consecutive failures that trigger lockout
//  LOCKOUT_CYCLES  500000000   clk cycles of lockout (5 s @ 100 MHz)
// PORTS
//  clk         in   1                    system clock, rising edge
//  rst_n       in   1                    asynchronous reset, active low
//  key_valid   in   1                    1-cycle strobe: key_code is valid
//  key_code    in   DIGIT_W              digit 0..9; values 10..15 are ignored
//  key_clear   in   1                    1-cycle strobe: discard partial entry
//  unlock      out  1                    door open; drives LED stage led_in
//  err_pulse   out  1                    1-cycle pulse on a wrong code
//  locked_out  out  1                    high during lockout
//  digit_cnt   out  $clog2(CODE_LEN+1)   digits entered so far
// BEHAVIOUR
//  Reset: async on rst_n low.
//   - All outputs go to 0; state=ENTRY; entry reg, fail_cnt and timer are cleared.
//  State machine (ENTRY, CHECK, OPEN, LOCKOUT); all outputs are registered.
//  ENTRY:
//   - key_valid with key_code<=9: shift the digit into the entry reg and
//     increment digit_cnt.
//   - key_valid with key_code>9: ignored; no state change.
//   - key_clear: digit_cnt=0 and entry reg cleared.
//     key_clear has priority over key_valid in the same cycle.
//   - On the edge that accepts digit CODE_LEN, go to CHECK.
//  CHECK (exactly 1 cycle): compare entry with PASSCODE.
//   - Match:
//     - go to OPEN; unlock=1 from this edge.
//     - Unlock therefore rises 2 clocks after the final digit is sampled.
//     - fail_cnt=0.
//   - Mismatch:
//     - err_pulse=1 for 1 cycle; fail_cnt+1.
//     - If the new fail_cnt==MAX_FAILS, go to LOCKOUT (locked_out=1 on the
//       same edge); otherwise go to ENTRY.
//   - In both cases, digit_cnt=0 and the entry reg is cleared.
//  OPEN:
//   - unlock stays high for exactly UNLOCK_CYCLES clocks, then drops to 0 and
//     state returns to ENTRY.
//   - key_valid and key_clear are ignored.
//  LOCKOUT:
//   - locked_out stays high for exactly LOCKOUT_CYCLES clocks; key inputs are
//     ignored.
//   - On exit: locked_out=0, fail_cnt=0, state=ENTRY.
//  Timer:
//   - One shared down-counter sized for max(UNLOCK_CYCLES, LOCKOUT_CYCLES).
//   - Loaded on entry to OPEN or LOCKOUT; no wrap; it is never reloaded while
//     running.
//  fail_cnt:
//   - Saturates at MAX_FAILS.
//   - Cleared only by a match, the end of lockout, or reset. key_clear does
//     not clear it.
//  Mid-operation reset: unlock, locked_out and err_pulse drop immediately
//   (async), and all progress is lost.
// TESTING (bench params: UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, MAX_FAILS=3,
//          PASSCODE=16'h1234)
//  1. Keys 1,2,3,4 -> unlock rises 2 clks after the '4' strobe, stays high
//     exactly 8 clks, then 0; digit_cnt is 0 afterwards.
//  2. Keys 1,2,3,5 -> err_pulse high for 1 clk, unlock stays 0, state back in
//     ENTRY; a following 1,2,3,4 unlocks.
//  3. Three wrong entries -> locked_out high for exactly 16 clks; a 1,2,3,4
//     during lockout has no effect; 1,2,3,4 after lockout unlocks.
//  4. Keys 1,2 then key_clear, then 1,2,3,4 -> unlock.
//     key_clear and key_valid(9) in the same cycle -> digit_cnt=0.
//  5. key_code 4'hB strobed in ENTRY -> digit_cnt unchanged.
//     Keys strobed during OPEN -> ignored; the unlock length is still 8.
//  6. rst_n low in the middle of OPEN and in the middle of LOCKOUT -> outputs
//     are 0 with no clock edge; after release, 1,2,3,4 unlocks.

Source files
------------

// File: rtl/passcode_checker.sv
// Door-lock decision stage: collects keypad digits, compares a complete entry
// against the stored passcode, holds 'unlock' for a fixed time and enforces a
// lockout after repeated wrong entries. All outputs are registered.
module passcode_checker #(
  parameter int                            CODE_LEN       = 4,
  parameter int                            DIGIT_W        = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   PASSCODE       = 16'h1234,
  parameter int unsigned                   UNLOCK_CYCLES  = 100000000,
  parameter int                            MAX_FAILS      = 3,
  parameter int unsigned                   LOCKOUT_CYCLES = 500000000,
  localparam int                           CNT_W          = $clog2(CODE_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_clear,
  output logic               unlock,
  output logic               err_pulse,
  output logic               locked_out,
  output logic [CNT_W-1:0]   digit_cnt
);

  localparam int          ENTRY_W   = CODE_LEN * DIGIT_W;
  localparam int unsigned TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                                      UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int          TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int          FAIL_W    = $clog2(MAX_FAILS + 1);

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  // The timer is loaded with N-1 so that the output stays high for exactly
  // N clocks: the loading edge raises it, the edge after the count reaches
  // zero drops it.
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_FAILS);
  localparam logic [CNT_W-1:0]   LAST_DIGIT   = CNT_W'(CODE_LEN - 1);
  localparam logic [DIGIT_W-1:0] MAX_DIGIT    = DIGIT_W'(9);

  logic [1:0]         state_q,      state_d;
  logic [ENTRY_W-1:0] entry_q,      entry_d;
  logic [CNT_W-1:0]   digit_cnt_q,  digit_cnt_d;
  logic [FAIL_W-1:0]  fail_cnt_q,   fail_cnt_d;
  logic [TIMER_W-1:0] timer_q,      timer_d;
  logic               unlock_q,     unlock_d;
  logic               err_pulse_q,  err_pulse_d;
  logic               locked_out_q, locked_out_d;
  logic [FAIL_W-1:0]  fail_next;

  // Next-state logic: digit collection, one-cycle compare, and the two timed states.
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    digit_cnt_d  = digit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    unlock_d     = unlock_q;
    locked_out_d = locked_out_q;
    err_pulse_d  = 1'b0;
    fail_next    = (fail_cnt_q >= FAIL_LIMIT) ? FAIL_LIMIT : fail_cnt_q + 1'b1;

    case (state_q)
      ST_ENTRY: begin
        if (key_clear) begin
          entry_d     = '0;
          digit_cnt_d = '0;
        end else if (key_valid && (key_code <= MAX_DIGIT)) begin
          entry_d     = ENTRY_W'({entry_q, key_code});
          digit_cnt_d = digit_cnt_q + 1'b1;
          if (digit_cnt_q == LAST_DIGIT) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        entry_d     = '0;
        digit_cnt_d = '0;
        if (entry_q == PASSCODE) begin
          state_d    = ST_OPEN;
          unlock_d   = 1'b1;
          fail_cnt_d = '0;
          timer_d    = UNLOCK_LOAD;
        end else begin
          err_pulse_d = 1'b1;
          fail_cnt_d  = fail_next;
          if (fail_next == FAIL_LIMIT) begin
            state_d      = ST_LOCKOUT;
            locked_out_d = 1'b1;
            timer_d      = LOCKOUT_LOAD;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        if (timer_q == '0) begin
          unlock_d = 1'b0;
          state_d  = ST_ENTRY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          locked_out_d = 1'b0;
          fail_cnt_d   = '0;
          state_d      = ST_ENTRY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  // State and output registers; asynchronous reset drops every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ENTRY;
      entry_q      <= '0;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      unlock_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      unlock_q     <= unlock_d;
      err_pulse_q  <= err_pulse_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign unlock     = unlock_q;
  assign err_pulse  = err_pulse_q;
  assign locked_out = locked_out_q;
  assign digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Directed testbench for passcode_checker. Each step pushes the expected
// registered outputs to a scoreboard queue; they are popped and compared
// one clock later, half a period away from the active edge.
module tb_passcode_checker;

  typedef struct packed {
    logic       unlock;
    logic       err;
    logic       locked;
    logic [2:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_clear = 1'b0;
  logic       unlock;
  logic       err_pulse;
  logic       locked_out;
  logic [2:0] digit_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  passcode_checker #(
    .CODE_LEN      (4),
    .DIGIT_W       (4),
    .PASSCODE      (16'h1234),
    .UNLOCK_CYCLES (8),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_clear (key_clear),
    .unlock    (unlock),
    .err_pulse (err_pulse),
    .locked_out(locked_out),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard step %0d: observed empty queue expected entry", step_no);
    end else begin
      e = exp_q.pop_front();
      checkField("unlock",     {3'b0, unlock},     {3'b0, e.unlock});
      checkField("err_pulse",  {3'b0, err_pulse},  {3'b0, e.err});
      checkField("locked_out", {3'b0, locked_out}, {3'b0, e.locked});
      checkField("digit_cnt",  {1'b0, digit_cnt},  {1'b0, e.cnt});
    end
  endtask

  // One clock step: drive inputs at a falling edge, expect outputs after the rising edge.
  task automatic applyStimulus(input logic kv, input logic [3:0] kc, input logic kcl,
                               input logic u, input logic e, input logic l, input logic [2:0] c);
    step_no++;
    key_valid = kv;
    key_code  = kc;
    key_clear = kcl;
    exp_q.push_back('{unlock: u, err: e, locked: l, cnt: c});
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
    key_clear = 1'b0;
    checkOutput();
  endtask

  task automatic checkNow(input logic u, input logic e, input logic l, input logic [2:0] c);
    step_no++;
    exp_q.push_back('{unlock: u, err: e, locked: l, cnt: c});
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input logic u, input logic e, input logic l, input logic [2:0] c);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, u, e, l, c);
  endtask

  // Four digits from an empty entry; the fourth leaves the DUT in the compare cycle.
  task automatic enterDigits(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
    applyStimulus(1'b1, d0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b1, d1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    applyStimulus(1'b1, d2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b1, d3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
  endtask

  // Correct code: unlock rises on the second edge after the last digit and lasts 8 clocks.
  task automatic unlockSequence();
    enterDigits(4'd1, 4'd2, 4'd3, 4'd4);
    idleCycles(8, 1'b1, 1'b0, 1'b0, 3'd0);
    idleCycles(1, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic wrongEntry(input logic [3:0] last, input logic expect_lock);
    enterDigits(4'd1, 4'd2, 4'd3, last);
    idleCycles(1, 1'b0, 1'b1, expect_lock, 3'd0);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(negedge clk);
    checkNow(1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;

    $display("[TB] correct code unlocks for 8 clocks");
    unlockSequence();

    $display("[TB] wrong code pulses err_pulse, then correct code unlocks");
    wrongEntry(4'd5, 1'b0);
    idleCycles(1, 1'b0, 1'b0, 1'b0, 3'd0);
    unlockSequence();

    $display("[TB] three wrong entries cause a 16 clock lockout");
    wrongEntry(4'd5, 1'b0);
    wrongEntry(4'd6, 1'b0);
    wrongEntry(4'd9, 1'b1);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    idleCycles(11, 1'b0, 1'b0, 1'b1, 3'd0);
    idleCycles(1, 1'b0, 1'b0, 1'b0, 3'd0);
    unlockSequence();

    $display("[TB] key_clear discards a partial entry and wins over key_valid");
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    unlockSequence();
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("[TB] non-decimal key ignored; keys during OPEN ignored");
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    idleCycles(1, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    idleCycles(2, 1'b1, 1'b0, 1'b0, 3'd0);
    idleCycles(1, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("[TB] asynchronous reset in the middle of OPEN");
    enterDigits(4'd1, 4'd2, 4'd3, 4'd4);
    idleCycles(3, 1'b1, 1'b0, 1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1 checkNow(1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    unlockSequence();

    $display("[TB] asynchronous reset in the middle of LOCKOUT");
    wrongEntry(4'd5, 1'b0);
    wrongEntry(4'd6, 1'b0);
    wrongEntry(4'd7, 1'b1);
    idleCycles(3, 1'b0, 1'b0, 1'b1, 3'd0);
    #2 rst_n = 1'b0;
    #1 checkNow(1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    unlockSequence();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
